lcd_pixel_source: RTL and testbench

LCD_PIXEL_SOURCE -- requirements
Module: lcd_pixel_source

---
 rtl/lcd_pixel_source.sv | 168 ++++++++++++++++
 tb/tb_lcd_pixel_source.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_source.sv
// lcd_pixel_source: LCD dot/line timing generator. It fetches pixels from a linear
// framebuffer and emits one write strobe per visible pixel.
// Latency: one ce between presenting pix_addr and sampling pix_data. The strobe and
// lcd_data are registered on that same ce.
// Backpressure: none. Timing advances on every ce, and the pixel memory must answer
// within one ce period.
//
// Ports:
//   clk, reset (sync, active-high), ce (dot enable), enable (LCD power request)
//   pix_addr / pix_data : pixel memory read port (BGR555 data)
//   lcd_clkena / lcd_data : one-clk pixel strobe and pixel value
//   lcd_mode, lcd_on, frame_start : status outputs
module lcd_pixel_source #(
  parameter int LINE_DOTS   = 456,
  parameter int FRAME_LINES = 154,
  parameter int VIS_LINES   = 144,
  parameter int VIS_PIX     = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        enable,
  output logic [14:0] pix_addr,
  input  logic [14:0] pix_data,
  output logic        lcd_clkena,
  output logic [14:0] lcd_data,
  output logic [1:0]  lcd_mode,
  output logic        lcd_on,
  output logic        frame_start
);

  localparam int DW = $clog2(LINE_DOTS);
  localparam int LW = $clog2(FRAME_LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [DW-1:0] DOT_LAST    = DW'(LINE_DOTS - 1);
  localparam logic [LW-1:0] LINE_LAST   = LW'(FRAME_LINES - 1);
  localparam logic [LW-1:0] VIS_END     = LW'(VIS_LINES);
  localparam logic [DW-1:0] XFER_FIRST  = DW'(80);
  localparam logic [DW-1:0] FETCH_FIRST = DW'(91);
  localparam logic [DW-1:0] FETCH_LAST  = DW'(91 + VIS_PIX - 1);
  localparam logic [DW-1:0] STB_FIRST   = DW'(92);
  localparam logic [DW-1:0] STB_LAST    = DW'(92 + VIS_PIX - 1);
  localparam logic [14:0]   PIX_STEP    = 15'(VIS_PIX);

  logic [DW-1:0] dot_q, dot_d, nxt_dot;
  logic [LW-1:0] line_q, line_d, nxt_line;
  logic          on_q, on_d;
  logic [1:0]    mode_q, mode_d;
  logic          clkena_q, clkena_d;
  logic          fs_q, fs_d;
  logic [14:0]   addr_q, addr_d;
  logic [14:0]   base_q, base_d;
  logic [14:0]   data_q, data_d;
  logic          vis;
  logic          new_frame;

  always_comb begin
    dot_d     = dot_q;
    line_d    = line_q;
    on_d      = on_q;
    mode_d    = mode_q;
    clkena_d  = 1'b0;
    fs_d      = 1'b0;
    addr_d    = addr_q;
    base_d    = base_q;
    data_d    = data_q;
    nxt_dot   = dot_q;
    nxt_line  = line_q;
    vis       = 1'b0;
    new_frame = 1'b0;

    if (!enable) begin
      // Power-down: abandon any partial line at once, regardless of ce.
      dot_d  = '0;
      line_d = '0;
      on_d   = 1'b0;
      mode_d = MODE_HBLANK;
      addr_d = '0;
      base_d = '0;
    end else if (ce) begin
      // The first ce after power-up enters line 0, dot 0 rather than dot 1.
      if (!on_q) begin
        nxt_dot  = '0;
        nxt_line = '0;
      end else if (dot_q == DOT_LAST) begin
        nxt_dot  = '0;
        nxt_line = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
      end else begin
        nxt_dot  = dot_q + 1'b1;
        nxt_line = line_q;
      end

      on_d      = 1'b1;
      dot_d     = nxt_dot;
      line_d    = nxt_line;
      vis       = (nxt_line < VIS_END);
      new_frame = (nxt_dot == '0) && (nxt_line == '0);
      fs_d      = new_frame;

      // The mode register reflects the dot being entered.
      if (!vis)
        mode_d = MODE_VBLANK;
      else if (nxt_dot < XFER_FIRST)
        mode_d = MODE_OAM;
      else if (nxt_dot <= STB_LAST)
        mode_d = MODE_XFER;
      else
        mode_d = MODE_HBLANK;

      // base_q tracks line*VIS_PIX. The first fetch of each line loads it, so
      // pix_addr stays at the line's last pixel through hblank and vblank.
      if (new_frame)
        base_d = '0;
      else if (nxt_dot == '0)
        base_d = base_q + PIX_STEP;

      if (new_frame)
        addr_d = '0;
      else if (vis && nxt_dot == FETCH_FIRST)
        addr_d = base_q;
      else if (vis && nxt_dot > FETCH_FIRST && nxt_dot <= FETCH_LAST)
        addr_d = addr_q + 1'b1;

      // pix_data answers the address presented during the previous dot.
      if (vis && nxt_dot >= STB_FIRST && nxt_dot <= STB_LAST) begin
        clkena_d = 1'b1;
        data_d   = pix_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dot_q    <= '0;
      line_q   <= '0;
      on_q     <= 1'b0;
      mode_q   <= MODE_HBLANK;
      clkena_q <= 1'b0;
      fs_q     <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      data_q   <= '0;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      on_q     <= on_d;
      mode_q   <= mode_d;
      clkena_q <= clkena_d;
      fs_q     <= fs_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      data_q   <= data_d;
    end
  end

  assign pix_addr    = addr_q;
  assign lcd_clkena  = clkena_q;
  assign lcd_data    = data_q;
  assign lcd_mode    = mode_q;
  assign lcd_on      = on_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_pixel_source.sv
// tb_lcd_pixel_source: directed bench for lcd_pixel_source with default geometry.
// Latency: outputs are sampled 1 time unit after each rising clk.
// Backpressure: not applicable. The pixel memory is modelled as pix_data = pix_addr.
module tb_lcd_pixel_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        enable;
  logic [14:0] pix_addr;
  logic [14:0] pix_data;
  logic        lcd_clkena;
  logic [14:0] lcd_data;
  logic [1:0]  lcd_mode;
  logic        lcd_on;
  logic        frame_start;

  always #5 clk = ~clk;

  assign pix_data = pix_addr;

  lcd_pixel_source dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .enable      (enable),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .lcd_clkena  (lcd_clkena),
    .lcd_data    (lcd_data),
    .lcd_mode    (lcd_mode),
    .lcd_on      (lcd_on),
    .frame_start (frame_start)
  );

  int total = 0;
  int bad   = 0;

  // Reference timing, taken from the line/dot tables in the requirements.
  int m_dot = 0, m_line = 0;
  bit m_on = 0;
  int exp_data = 0;
  int ncyc = 0, fs_cnt = 0, t_fs1 = 0, period = 0;
  int nstb = 0, mode_err = 0, stb_err = 0, fs_err = 0, data_err = 0, hold_err = 0;
  int l5_m2 = 0, l5_m3 = 0, l5_m0 = 0;
  int l5_first_dot = -1, l5_first_dat = -1, l5_last_dot = -1, l5_last_dat = -1;
  int vb_mode1 = 0, vb_stb = 0;
  int addr_last = -1, addr_fs2 = -1;
  logic [14:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_mode_f(input int l, input int d);
    if (l >= 144) return 2'd1;
    if (d < 80)   return 2'd2;
    if (d < 252)  return 2'd3;
    return 2'd0;
  endfunction

  task automatic clear_stats();
    nstb = 0; mode_err = 0; stb_err = 0; fs_err = 0; data_err = 0; hold_err = 0;
  endtask

  // One clk with enable=1 and the given ce. Advances the model and tallies errors.
  task automatic step(input logic ce_v);
    logic exp_stb, exp_fs;
    logic [1:0] em;
    ce = ce_v;
    @(posedge clk); #1;
    ncyc++;
    if (ce_v) begin
      if (!m_on) begin
        m_on = 1; m_dot = 0; m_line = 0;
      end else begin
        m_dot++;
        if (m_dot == 456) begin
          m_dot = 0;
          m_line = (m_line == 153) ? 0 : m_line + 1;
        end
      end
    end
    em      = m_on ? exp_mode_f(m_line, m_dot) : 2'd0;
    exp_stb = ce_v && m_on && m_line < 144 && m_dot >= 92 && m_dot <= 251;
    exp_fs  = ce_v && m_on && m_dot == 0 && m_line == 0;
    if (lcd_mode !== em) mode_err++;
    if (lcd_clkena !== exp_stb) stb_err++;
    if (frame_start !== exp_fs) fs_err++;
    if (exp_fs) begin
      fs_cnt++;
      exp_data = 0;
      if (fs_cnt == 1) t_fs1 = ncyc;
      if (fs_cnt == 2) begin period = ncyc - t_fs1; addr_fs2 = int'(pix_addr); end
    end
    if (lcd_clkena === 1'b1) begin
      nstb++;
      if (lcd_data !== 15'(exp_data)) data_err++;
      exp_data++;
      if (m_line == 5) begin
        if (l5_first_dot < 0) begin l5_first_dot = m_dot; l5_first_dat = int'(lcd_data); end
        l5_last_dot = m_dot; l5_last_dat = int'(lcd_data);
      end
    end
    if (m_on && !(m_dot >= 91 && m_dot <= 250) && !(m_dot == 0 && m_line == 0)
        && pix_addr !== prev_addr) hold_err++;
    prev_addr = pix_addr;
    if (ce_v && m_line == 143 && m_dot == 250) addr_last = int'(pix_addr);
    if (ce_v && fs_cnt == 1 && m_line == 5) begin
      if (lcd_mode == 2'd2) l5_m2++;
      else if (lcd_mode == 2'd3) l5_m3++;
      else if (lcd_mode == 2'd0) l5_m0++;
    end
    if (ce_v && fs_cnt == 1 && m_line >= 144) begin
      if (lcd_mode == 2'd1) vb_mode1++;
      if (lcd_clkena === 1'b1) vb_stb++;
    end
  endtask

  task automatic run_to(input string tag, input int l, input int d);
    int n = 0;
    while (!(m_on && m_line == l && m_dot == d) && n < 40000) begin
      step(1'b1);
      n++;
    end
    chk(tag, 32'(m_on && m_line == l && m_dot == d), 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_on",     32'(lcd_on),      32'd0);
    chk("rst_mode",   32'(lcd_mode),    32'd0);
    chk("rst_addr",   32'(pix_addr),    32'd0);
    chk("rst_clkena", 32'(lcd_clkena),  32'd0);
    chk("rst_fs",     32'(frame_start), 32'd0);

    // Full frame with ce every clk.
    reset = 1'b0; enable = 1'b1;
    begin
      int n = 0;
      while (fs_cnt < 2 && n < 70400) begin step(1'b1); n++; end
    end
    chk("frm_seen",     32'(fs_cnt),    32'd2);
    chk("frm_period",   32'(period),    32'd70224);
    chk("frm_strobes",  32'(nstb - 0),  32'd23040);
    chk("frm_data_err", 32'(data_err),  32'd0);
    chk("frm_mode_err", 32'(mode_err),  32'd0);
    chk("frm_stb_err",  32'(stb_err),   32'd0);
    chk("frm_fs_err",   32'(fs_err),    32'd0);
    chk("frm_hold_err", 32'(hold_err),  32'd0);
    chk("addr_last",    32'(addr_last), 32'd23039);
    chk("addr_fs2",     32'(addr_fs2),  32'd0);
    chk("l5_mode2",     32'(l5_m2),     32'd80);
    chk("l5_mode3",     32'(l5_m3),     32'd172);
    chk("l5_mode0",     32'(l5_m0),     32'd204);
    chk("l5_first_dot", 32'(l5_first_dot), 32'd92);
    chk("l5_first_dat", 32'(l5_first_dat), 32'd800);
    chk("l5_last_dot",  32'(l5_last_dot),  32'd251);
    chk("l5_last_dat",  32'(l5_last_dat),  32'd959);
    chk("vb_mode1",     32'(vb_mode1),  32'd4560);
    chk("vb_strobes",   32'(vb_stb),    32'd0);

    // ce one clk in four for two lines of the next frame.
    clear_stats();
    for (int i = 0; i < 2 * 456; i++) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end
    chk("ce4_strobes",  32'(nstb),     32'd320);
    chk("ce4_data_err", 32'(data_err), 32'd0);
    chk("ce4_mode_err", 32'(mode_err), 32'd0);
    chk("ce4_stb_err",  32'(stb_err),  32'd0);
    chk("ce4_fs_err",   32'(fs_err),   32'd0);

    // Reset pulsed during mode 3 of line 10.
    run_to("rst_reach", 10, 150);
    reset = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    chk("midrst_on",     32'(lcd_on),      32'd0);
    chk("midrst_mode",   32'(lcd_mode),    32'd0);
    chk("midrst_addr",   32'(pix_addr),    32'd0);
    chk("midrst_clkena", 32'(lcd_clkena),  32'd0);
    chk("midrst_data",   32'(lcd_data),    32'd0);
    chk("midrst_fs",     32'(frame_start), 32'd0);
    @(posedge clk); #1;
    chk("midrst_clkena2", 32'(lcd_clkena), 32'd0);
    reset = 1'b0;
    m_on = 0; prev_addr = '0; exp_data = 0;
    clear_stats();
    step(1'b1);
    chk("rstart_fs",   32'(frame_start), 32'd1);
    chk("rstart_mode", 32'(lcd_mode),    32'd2);
    repeat (455) step(1'b1);
    chk("rstart_strobes",  32'(nstb),     32'd160);
    chk("rstart_data_err", 32'(data_err), 32'd0);
    chk("rstart_mode_err", 32'(mode_err), 32'd0);
    chk("rstart_stb_err",  32'(stb_err),  32'd0);

    // Enable dropped mid-line, then raised again.
    run_to("dis_reach", 20, 150);
    chk("dis_addr_before", 32'(pix_addr != 15'd0), 32'd1);
    enable = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
    chk("dis_on",     32'(lcd_on),     32'd0);
    chk("dis_addr",   32'(pix_addr),   32'd0);
    chk("dis_mode",   32'(lcd_mode),   32'd0);
    chk("dis_clkena", 32'(lcd_clkena), 32'd0);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("dis_on_held", 32'(lcd_on), 32'd0);
    enable = 1'b1;
    m_on = 0; prev_addr = '0; exp_data = 0;
    clear_stats();
    step(1'b1);
    chk("reen_fs", 32'(frame_start), 32'd1);
    chk("reen_on", 32'(lcd_on),      32'd1);
    repeat (92) step(1'b1);
    chk("reen_first_stb", 32'(lcd_clkena), 32'd1);
    chk("reen_first_dat", 32'(lcd_data),   32'd0);
    chk("reen_mode_err",  32'(mode_err),   32'd0);
    chk("reen_stb_err",   32'(stb_err),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
